// File: rtl/serial_addsub_if.sv
// Digit-serial add/subtract bus.
//   master: drives valid_i/start_i/sub_i/x_i/y_i and observes the results.
//   slave : the adder side. It consumes the operand digits and drives
//           sum_o/valid_o/last_o/cout_o/ovf_o/busy_o.
interface serial_addsub_if #(
  parameter int DIGIT = 1
);
  logic             valid_i;
  logic             start_i;
  logic             sub_i;
  logic [DIGIT-1:0] x_i;
  logic [DIGIT-1:0] y_i;
  logic [DIGIT-1:0] sum_o;
  logic             valid_o;
  logic             last_o;
  logic             cout_o;
  logic             ovf_o;
  logic             busy_o;

  modport master (
    output valid_i, start_i, sub_i, x_i, y_i,
    input  sum_o, valid_o, last_o, cout_o, ovf_o, busy_o
  );

  modport slave (
    input  valid_i, start_i, sub_i, x_i, y_i,
    output sum_o, valid_o, last_o, cout_o, ovf_o, busy_o
  );
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial two's-complement adder/subtractor.
// Words of WIDTH bits arrive LSB-first, DIGIT bits per cycle.
// The result digit is registered, so it appears one cycle after acceptance.
// The MSB digit carries last_o, together with the word's carry-out and
// signed-overflow flags.
//   clk_i : clock, rising edge
//   rst_i : asynchronous reset, active-high
//   bus   : serial_addsub_if slave
//           in : valid_i, start_i, sub_i, x_i, y_i
//           out: sum_o, valid_o, last_o, cout_o, ovf_o, busy_o
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  serial_addsub_if.slave    bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             m;

  logic             accept;
  logic             mode;
  logic             cin;
  logic [DIGIT-1:0] yx;
  logic [DIGIT:0]   full;
  logic             cmsb;
  logic [CW-1:0]    cur_cnt;
  logic             is_last;

  always_comb begin
    accept  = bus.valid_i && (bus.start_i || state == RUN);
    // A start digit takes its mode and carry-in from sub_i directly.
    // This lets a new word restart the datapath in the same cycle,
    // including an abort of a word already in RUN.
    mode    = bus.start_i ? bus.sub_i : m;
    cin     = bus.start_i ? bus.sub_i : c;
    cur_cnt = bus.start_i ? '0 : cnt;
    yx      = bus.y_i ^ {DIGIT{mode}};
    full    = {1'b0, bus.x_i} + {1'b0, yx} + {{DIGIT{1'b0}}, cin};
    // Carry into the top bit of the digit is recovered from its sum bit.
    cmsb    = full[DIGIT-1] ^ bus.x_i[DIGIT-1] ^ yx[DIGIT-1];
    is_last = (cur_cnt == CW'(NDIG - 1));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      c           <= 1'b0;
      m           <= 1'b0;
      bus.sum_o   <= '0;
      bus.valid_o <= 1'b0;
      bus.last_o  <= 1'b0;
      bus.cout_o  <= 1'b0;
      bus.ovf_o   <= 1'b0;
      bus.busy_o  <= 1'b0;
    end else begin
      bus.valid_o <= accept;
      bus.last_o  <= accept && is_last;
      bus.cout_o  <= accept && is_last && full[DIGIT];
      bus.ovf_o   <= accept && is_last && (cmsb ^ full[DIGIT]);
      if (accept) begin
        bus.sum_o <= full[DIGIT-1:0];
        c         <= full[DIGIT];
        m         <= mode;
        if (is_last) begin
          state      <= IDLE;
          cnt        <= '0;
          bus.busy_o <= 1'b0;
        end else begin
          state      <= RUN;
          cnt        <= cur_cnt + CW'(1);
          bus.busy_o <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_addsub_if #(.DIGIT(1)) b1 ();
  serial_addsub_if #(.DIGIT(4)) b4 ();

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u1 (.clk_i(clk), .rst_i(rst), .bus(b1));
  serial_addsub #(.WIDTH(8), .DIGIT(4)) u4 (.clk_i(clk), .rst_i(rst), .bus(b4));

  typedef struct {
    logic [3:0] sum;
    bit         last;
    bit         cout;
    bit         ovf;
  } exp_t;

  typedef struct {
    bit         sub;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] sum;
    bit         cout;
    bit         ovf;
  } vec_t;

  exp_t q1[$];
  exp_t q4[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Scoreboard: every valid result digit pops one expected record.
  // The packed compare value is {last, cout, ovf, 0, sum}.
  always @(negedge clk) begin
    exp_t e;
    if (b1.valid_o) begin
      if (q1.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL dut1 unexpected digit: got sum=%0h last=%b, want none", b1.sum_o, b1.last_o);
      end else begin
        e = q1.pop_front();
        chk("dut1 digit {last,cout,ovf,sum}", {b1.last_o, b1.cout_o, b1.ovf_o, 3'b000, b1.sum_o},
            {e.last, e.cout, e.ovf, e.sum});
      end
    end else if (!rst) begin
      chk("dut1 idle flags", {b1.last_o, b1.cout_o, b1.ovf_o}, 0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b4.valid_o) begin
      if (q4.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL dut4 unexpected digit: got sum=%0h last=%b, want none", b4.sum_o, b4.last_o);
      end else begin
        e = q4.pop_front();
        chk("dut4 digit {last,cout,ovf,sum}", {b4.last_o, b4.cout_o, b4.ovf_o, b4.sum_o},
            {e.last, e.cout, e.ovf, e.sum});
      end
    end else if (!rst) begin
      chk("dut4 idle flags", {b4.last_o, b4.cout_o, b4.ovf_o}, 0);
    end
  end

  task automatic drv1(input bit v, input bit st, input bit sb, input logic x, input logic y);
    b1.valid_i = v; b1.start_i = st; b1.sub_i = sb; b1.x_i = x; b1.y_i = y;
    @(posedge clk); #1;
  endtask

  task automatic drv4(input bit v, input bit st, input bit sb, input logic [3:0] x, input logic [3:0] y);
    b4.valid_i = v; b4.start_i = st; b4.sub_i = sb; b4.x_i = x; b4.y_i = y;
    @(posedge clk); #1;
  endtask

  // Send the first n digits of a word.
  // sub_i is inverted on non-start digits because the mode must come
  // only from the start digit.
  // If stall_after is set, three idle cycles follow that digit index.
  task automatic word1(input bit sb, input logic [7:0] x, input logic [7:0] y, input logic [7:0] es,
                       input bit ec, input bit eo, input int n, input int stall_after);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.sum  = {3'b000, es[i]};
      e.last = (i == 7);
      e.cout = (i == 7) ? ec : 1'b0;
      e.ovf  = (i == 7) ? eo : 1'b0;
      q1.push_back(e);
      drv1(1'b1, i == 0, (i == 0) ? sb : ~sb, x[i], y[i]);
      if (i == stall_after) begin
        for (int s = 0; s < 3; s++) begin
          drv1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
          chk("stall valid_o", b1.valid_o, 0);
          chk("stall busy_o", b1.busy_o, 1);
        end
      end
    end
  endtask

  task automatic word4(input bit sb, input logic [7:0] x, input logic [7:0] y, input logic [7:0] es,
                       input bit ec, input bit eo);
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      e.sum  = es[i*4 +: 4];
      e.last = (i == 1);
      e.cout = (i == 1) ? ec : 1'b0;
      e.ovf  = (i == 1) ? eo : 1'b0;
      q4.push_back(e);
      drv4(1'b1, i == 0, (i == 0) ? sb : ~sb, x[i*4 +: 4], y[i*4 +: 4]);
    end
  endtask

  vec_t tv1[7];
  vec_t tv4[4];

  initial begin
    tv1[0] = '{1'b0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0};
    tv1[1] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    tv1[2] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    tv1[3] = '{1'b1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0};
    tv1[4] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    tv1[5] = '{1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0};
    tv1[6] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    tv4[0] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    tv4[1] = '{1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
    tv4[2] = '{1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0};
    tv4[3] = '{1'b0, 8'h40, 8'h40, 8'h80, 1'b0, 1'b1};

    b1.valid_i = 0; b1.start_i = 0; b1.sub_i = 0; b1.x_i = '0; b1.y_i = '0;
    b4.valid_i = 0; b4.start_i = 0; b4.sub_i = 0; b4.x_i = '0; b4.y_i = '0;

    // Asynchronous reset, checked before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("reset dut1 {valid,last,cout,ovf,busy,sum}",
        {b1.valid_o, b1.last_o, b1.cout_o, b1.ovf_o, b1.busy_o, b1.sum_o}, 0);
    chk("reset dut4 {valid,last,cout,ovf,busy,sum}",
        {b4.valid_o, b4.last_o, b4.cout_o, b4.ovf_o, b4.busy_o, b4.sum_o}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Table words, sent back to back.
    for (int k = 0; k < 7; k++)
      word1(tv1[k].sub, tv1[k].x, tv1[k].y, tv1[k].sum, tv1[k].cout, tv1[k].ovf, 8, -1);
    drv1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // In IDLE, valid digits without start are ignored.
    for (int k = 0; k < 2; k++) begin
      drv1(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("idle no-start valid_o", b1.valid_o, 0);
      chk("idle no-start busy_o", b1.busy_o, 0);
    end

    // Stall of three cycles after digit 2; the carry must survive it.
    word1(1'b0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 8, 1);
    drv1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // A mid-word reset discards the partial word.
    word1(1'b0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 4, -1);
    chk("mid-word busy_o", b1.busy_o, 1);
    b1.valid_i = 1'b0;
    @(negedge clk); #1 rst = 1'b1;
    #1;
    chk("mid-word reset {valid,last,busy}", {b1.valid_o, b1.last_o, b1.busy_o}, 0);
    @(posedge clk); #1 rst = 1'b0;
    drv1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post-reset valid_o", b1.valid_o, 0);
    word1(1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 8, -1);
    drv1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // A start digit mid-word aborts the word; the aborted word gets no last_o.
    word1(1'b1, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 3, -1);
    word1(1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 8, -1);
    for (int k = 0; k < 3; k++) drv1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("dut1 scoreboard drained", q1.size(), 0);

    // DIGIT=4 words, sent back to back.
    for (int k = 0; k < 4; k++)
      word4(tv4[k].sub, tv4[k].x, tv4[k].y, tv4[k].sum, tv4[k].cout, tv4[k].ovf);
    for (int k = 0; k < 3; k++) drv4(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("dut4 busy_o idle", b4.busy_o, 0);
    chk("dut4 scoreboard drained", q4.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
